// File: rtl/attack_bar.sv
// rtl/attack_bar.sv - player attack timing bar: sweeping cursor, press-to-stop damage, bar overlay pixels
module attack_bar #(
    parameter logic [3:0] STATE_CODE  = 4'b0001,
    parameter int         BAR_X       = 256,
    parameter int         BAR_Y       = 400,
    parameter int         BAR_W       = 512,
    parameter int         BAR_H       = 32,
    parameter int         STEP        = 4,
    parameter int         FRAME_V     = 768,
    parameter int         MAX_DMG     = 32,
    parameter int         DMG_SHIFT   = 3,
    parameter int         HOLD_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [3:0]  state_in,
    input  logic [1:0]  rotate_in,
    output logic        busy_out,
    output logic        finished_out,
    output logic        damage_valid_out,
    output logic [7:0]  damage_amt_out,
    output logic [11:0] pixel_out
);

    // Bar geometry widened so BAR_X+BAR_W and BAR_Y+BAR_H never wrap.
    localparam logic [11:0] X_LO      = 12'(BAR_X);
    localparam logic [11:0] X_HI      = 12'(BAR_X + BAR_W);
    localparam logic [10:0] Y_LO      = 11'(BAR_Y);
    localparam logic [10:0] Y_HI      = 11'(BAR_Y + BAR_H);
    localparam logic [10:0] X_OFF     = 11'(BAR_X);
    localparam logic [10:0] W_BAR     = 11'(BAR_W);
    localparam logic [10:0] STEP_W    = 11'(STEP);
    localparam logic [9:0]  HALF      = 10'(BAR_W / 2);
    localparam logic [10:0] CTR_LO    = 11'(BAR_W / 2 - 8);
    localparam logic [10:0] CTR_HI    = 11'(BAR_W / 2 + 8);
    localparam logic [9:0]  V_TICK    = 10'(FRAME_V);
    localparam logic [9:0]  MAX_D10   = 10'(MAX_DMG);
    localparam logic [7:0]  MAX_D8    = 8'(MAX_DMG);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_SWEEP = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_btn;
    logic [9:0]  r_cursor;
    logic        r_miss;
    logic [7:0]  r_hold_cnt;
    logic        r_dmg_valid;
    logic [7:0]  r_dmg_amt;
    logic [11:0] r_pixel;

    logic        w_tick;
    logic        w_active;
    logic        w_press;
    logic [10:0] w_cur_next;
    logic        w_end;
    logic        w_hold_done;
    logic        w_hit;
    logic        w_miss;
    logic        w_advance;
    logic        w_draw;
    logic [9:0]  w_dist;
    logic [9:0]  w_shift;
    logic [7:0]  w_dmg_diff;
    logic [7:0]  w_dmg;
    logic        w_in_x;
    logic        w_in_y;
    logic [10:0] w_rel;
    logic [10:0] w_cur_lo;
    logic        w_cur_col;
    logic        w_ctr;

    // Frame tick, button edge, cursor step and result conditions.
    always_comb begin
        w_tick      = (hcount_in == 11'd0) && (vcount_in == V_TICK);
        w_active    = (state_in == STATE_CODE);
        w_press     = rotate_in[0] & ~r_btn;
        w_cur_next  = {1'b0, r_cursor} + STEP_W;
        w_end       = (w_cur_next >= W_BAR);
        w_hold_done = w_tick && (r_hold_cnt == HOLD_LAST);
        // A press beats end-of-bar in the same cycle; leaving the state code beats both.
        w_hit       = (r_state == S_SWEEP) && w_active && w_press;
        w_miss      = (r_state == S_SWEEP) && w_active && !w_press && w_tick && w_end;
        w_advance   = (r_state == S_SWEEP) && w_active && !w_press && w_tick && !w_end;
    end

    // Damage from distance to bar centre, saturating at zero.
    always_comb begin
        w_dist     = (r_cursor >= HALF) ? (r_cursor - HALF) : (HALF - r_cursor);
        w_shift    = w_dist >> DMG_SHIFT;
        w_dmg_diff = MAX_D8 - w_shift[7:0];
        w_dmg      = (w_shift >= MAX_D10) ? 8'd0 : w_dmg_diff;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; any loss of the state code before DONE aborts silently.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_active) w_state_nxt = S_ARM;
            end
            S_ARM: begin
                if (!w_active)   w_state_nxt = S_IDLE;
                else if (w_tick) w_state_nxt = S_SWEEP;
            end
            S_SWEEP: begin
                if (!w_active)          w_state_nxt = S_IDLE;
                else if (w_hit || w_miss) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!w_active)        w_state_nxt = S_IDLE;
                else if (w_hold_done) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (!w_active) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy_out     = (r_state == S_SWEEP) || (r_state == S_HOLD);
        finished_out = (r_state == S_DONE);
        w_draw       = (r_state == S_ARM) || (r_state == S_SWEEP) || (r_state == S_HOLD);
    end

    // Previous button level for rising-edge detection, tracked in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn <= 1'b0;
        end else begin
            r_btn <= rotate_in[0];
        end
    end

    // Cursor: cleared when the sweep starts, stepped per tick, frozen once a result exists.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cursor <= 10'd0;
        end else if ((r_state == S_ARM) && w_active && w_tick) begin
            r_cursor <= 10'd0;
        end else if (w_advance) begin
            r_cursor <= w_cur_next[9:0];
        end
    end

    // Miss flag selects the red cursor while the result is on screen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_miss <= 1'b0;
        end else if ((r_state == S_ARM) && w_active && w_tick) begin
            r_miss <= 1'b0;
        end else if (w_miss) begin
            r_miss <= 1'b1;
        end
    end

    // Counts frame ticks while the result is displayed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_cnt <= 8'd0;
        end else if (r_state != S_HOLD) begin
            r_hold_cnt <= 8'd0;
        end else if (w_tick) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
        end
    end

    // Result pulse and held damage amount; only one result per round can exist.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dmg_valid <= 1'b0;
            r_dmg_amt   <= 8'd0;
        end else begin
            r_dmg_valid <= w_hit || w_miss;
            if (w_hit) begin
                r_dmg_amt <= w_dmg;
            end else if (w_miss) begin
                r_dmg_amt <= 8'd0;
            end
        end
    end

    // Bar-rectangle, cursor-column and centre-zone hit tests for the current pixel.
    always_comb begin
        w_in_x    = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} < X_HI);
        w_in_y    = ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI);
        w_rel     = hcount_in - X_OFF;
        w_cur_lo  = {1'b0, r_cursor};
        w_cur_col = (w_rel >= w_cur_lo) && (w_rel < (w_cur_lo + 11'd4));
        w_ctr     = (w_rel > CTR_LO) && (w_rel < CTR_HI);
    end

    // Registered pixel: black outside the bar or when this block is not on screen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pixel <= 12'h000;
        end else if (!w_draw || !w_in_x || !w_in_y) begin
            r_pixel <= 12'h000;
        end else if (w_cur_col) begin
            r_pixel <= ((r_state == S_HOLD) && r_miss) ? 12'hF00 : 12'hFFF;
        end else if (w_ctr) begin
            r_pixel <= 12'h0F0;
        end else begin
            r_pixel <= 12'h444;
        end
    end

    assign damage_valid_out = r_dmg_valid;
    assign damage_amt_out   = r_dmg_amt;
    assign pixel_out        = r_pixel;

endmodule

// File: tb/tb_attack_bar.sv
// tb/tb_attack_bar.sv - self-checking bench for attack_bar
module tb_attack_bar;

    localparam int BX = 256;
    localparam int BY = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount_in = 11'd1;
    logic [9:0]  vcount_in = 10'd0;
    logic [3:0]  state_in = 4'd0;
    logic [1:0]  rotate_in = 2'd0;
    logic        busy_out;
    logic        finished_out;
    logic        damage_valid_out;
    logic [7:0]  damage_amt_out;
    logic [11:0] pixel_out;

    attack_bar dut (
        .clk              (clk),
        .rst              (rst),
        .hcount_in        (hcount_in),
        .vcount_in        (vcount_in),
        .state_in         (state_in),
        .rotate_in        (rotate_in),
        .busy_out         (busy_out),
        .finished_out     (finished_out),
        .damage_valid_out (damage_valid_out),
        .damage_amt_out   (damage_amt_out),
        .pixel_out        (pixel_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          h;
        int          v;
        logic [11:0] px;
    } pix_vec_t;

    typedef struct {
        int          ticks;
        logic [7:0]  dmg;
    } round_vec_t;

    int         n_checks = 0;
    int         n_fail = 0;
    int         pulses = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every result pulse must match the oldest expected damage.
    always @(negedge clk) begin
        if (rst && damage_valid_out) begin
            pulses++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: damage_valid_out=1 amt=%0d, expected no pulse", damage_amt_out);
            end else begin
                chk("damage_amt_at_pulse", 32'(damage_amt_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            hcount_in = 11'd0;
            vcount_in = 10'd768;
            cyc();
            hcount_in = 11'd1;
            vcount_in = 10'd0;
        end
    endtask

    task automatic probe(input string nm, input int h, input int v, input logic [11:0] px);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        cyc();
        chk(nm, 32'(pixel_out), 32'(px));
        hcount_in = 11'd1;
        vcount_in = 10'd0;
    endtask

    task automatic start_round();
        state_in = 4'b0001;
        cyc();
        tick_n(1);
    endtask

    task automatic press(input logic [7:0] dmg);
        rotate_in = 2'b01;
        exp_q.push_back(dmg);
        cyc();
        rotate_in = 2'b00;
        cyc();
    endtask

    task automatic finish_round(input logic [7:0] dmg);
        chk("busy_in_hold", 32'(busy_out), 32'd1);
        chk("damage_amt_held", 32'(damage_amt_out), 32'(dmg));
        tick_n(29);
        chk("finished_before_30", 32'(finished_out), 32'd0);
        tick_n(1);
        chk("finished_after_30", 32'(finished_out), 32'd1);
        chk("busy_in_done", 32'(busy_out), 32'd0);
        state_in = 4'b1000;
        #1;
        chk("finished_same_cycle", 32'(finished_out), 32'd1);
        cyc();
        chk("finished_dropped", 32'(finished_out), 32'd0);
        state_in = 4'b0000;
        cyc();
    endtask

    pix_vec_t   pv[13];
    round_vec_t rv[4];

    initial begin
        pv = '{
            '{BX + 256, BY + 5,  12'h0F0},
            '{BX - 1,   BY,      12'h000},
            '{BX,       BY,      12'hFFF},
            '{BX + 3,   BY + 31, 12'hFFF},
            '{BX + 4,   BY,      12'h444},
            '{BX + 248, BY,      12'h444},
            '{BX + 249, BY,      12'h0F0},
            '{BX + 263, BY + 31, 12'h0F0},
            '{BX + 264, BY,      12'h444},
            '{BX + 511, BY,      12'h444},
            '{BX + 512, BY,      12'h000},
            '{BX,       BY - 1,  12'h000},
            '{BX,       BY + 32, 12'h000}
        };
        rv = '{
            '{64, 8'd32},
            '{50, 8'd25},
            '{0,  8'd0},
            '{75, 8'd27}
        };

        repeat (3) cyc();
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_finished", 32'(finished_out), 32'd0);
        chk("rst_valid", 32'(damage_valid_out), 32'd0);
        chk("rst_amt", 32'(damage_amt_out), 32'd0);
        chk("rst_pixel", 32'(pixel_out), 32'd0);
        rst = 1'b1;
        cyc();

        // Press rounds from the table; the first also walks the pixel table at cursor 0.
        for (int r = 0; r < 4; r++) begin
            start_round();
            if (r == 0) begin
                chk("busy_in_sweep", 32'(busy_out), 32'd1);
                for (int i = 0; i < 13; i++) begin
                    probe($sformatf("pixel_vec%0d", i), pv[i].h, pv[i].v, pv[i].px);
                end
            end
            pulses = 0;
            tick_n(rv[r].ticks);
            press(rv[r].dmg);
            chk($sformatf("round%0d_pulses", r), 32'(pulses), 32'd1);
            finish_round(rv[r].dmg);
        end

        // Miss: cursor reaches 508, the 128th tick ends the sweep.
        start_round();
        pulses = 0;
        tick_n(127);
        probe("miss_cursor_white", BX + 508, BY, 12'hFFF);
        chk("miss_no_early_pulse", 32'(pulses), 32'd0);
        exp_q.push_back(8'd0);
        tick_n(1);
        probe("miss_cursor_red", BX + 508, BY + 1, 12'hF00);
        probe("miss_next_col", BX + 507, BY, 12'h444);
        chk("miss_pulses", 32'(pulses), 32'd1);
        finish_round(8'd0);

        // Button held from ARM gives no edge; release and re-press at cursor 300.
        rotate_in = 2'b01;
        start_round();
        pulses = 0;
        tick_n(75);
        chk("held_no_pulse", 32'(pulses), 32'd0);
        probe("held_still_sweeping", BX + 300, BY, 12'hFFF);
        rotate_in = 2'b00;
        cyc();
        press(8'd27);
        chk("held_then_press_pulses", 32'(pulses), 32'd1);
        finish_round(8'd27);

        // Abort mid-sweep.
        start_round();
        pulses = 0;
        tick_n(10);
        state_in = 4'b0000;
        cyc();
        chk("abort_busy", 32'(busy_out), 32'd0);
        probe("abort_pixel", BX + 40, BY, 12'h000);
        tick_n(3);
        chk("abort_no_pulse", 32'(pulses), 32'd0);
        chk("abort_finished", 32'(finished_out), 32'd0);
        chk("abort_amt_kept", 32'(damage_amt_out), 32'd27);

        // Asynchronous reset mid-sweep at cursor 100.
        start_round();
        tick_n(25);
        hcount_in = 11'(BX + 100);
        vcount_in = 10'(BY);
        cyc();
        chk("pre_reset_pixel", 32'(pixel_out), 32'hFFF);
        chk("pre_reset_busy", 32'(busy_out), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        chk("async_busy", 32'(busy_out), 32'd0);
        chk("async_amt", 32'(damage_amt_out), 32'd0);
        chk("async_pixel", 32'(pixel_out), 32'd0);
        chk("async_valid", 32'(damage_valid_out), 32'd0);
        state_in = 4'b0000;
        hcount_in = 11'd1;
        vcount_in = 10'd0;
        cyc();
        rst = 1'b1;
        cyc();
        probe("post_reset_idle_pixel", BX, BY, 12'h000);
        state_in = 4'b0001;
        cyc();
        probe("post_reset_cursor0", BX, BY, 12'hFFF);
        probe("post_reset_col100", BX + 100, BY, 12'h444);
        state_in = 4'b0000;
        cyc();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
